sprite_plot_scheduler: RTL and testbench

//  Single owner of the VGA pixel-write port. Serialises three requester classes: alien kill-erase, alien-row shift-down, shot move.

---
 rtl/sprite_plot_scheduler_if.sv | 37 +++
 rtl/sprite_plot_scheduler.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_plot_scheduler_if.sv
// Pixel-write arbitration bus between the sprite/shot requesters and the plot scheduler.
// master = requester side, slave = scheduler side.
interface sprite_plot_scheduler_if;
    logic [4:0] kill_req;
    logic [7:0] alien_top_x;
    logic [6:0] alien_top_y;
    logic [7:0] alien_bot_x;
    logic [6:0] alien_bot_y;
    logic       shift_req;
    logic [6:0] row_y;
    logic       shot_req;
    logic [7:0] shot_old_x;
    logic [6:0] shot_old_y;
    logic [7:0] shot_new_x;
    logic [6:0] shot_new_y;
    logic [4:0] cleared;
    logic       cleared_shift;
    logic       shot_done;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot;
    logic       busy;
    logic [4:0] alive_mask;

    modport master (
        output kill_req, alien_top_x, alien_top_y, alien_bot_x, alien_bot_y,
               shift_req, row_y, shot_req, shot_old_x, shot_old_y, shot_new_x, shot_new_y,
        input  cleared, cleared_shift, shot_done, plot_x, plot_y, plot_colour, plot, busy, alive_mask
    );

    modport slave (
        input  kill_req, alien_top_x, alien_top_y, alien_bot_x, alien_bot_y,
               shift_req, row_y, shot_req, shot_old_x, shot_old_y, shot_new_x, shot_new_y,
        output cleared, cleared_shift, shot_done, plot_x, plot_y, plot_colour, plot, busy, alive_mask
    );
endinterface

// File: rtl/sprite_plot_scheduler.sv
// Sole owner of the VGA pixel port: serialises kill-erase, row shift-down and shot moves into plot streams.
// Define SCHED_ROUND_ROBIN_EN for rotating class priority; default is fixed kill > shift > shot.
module sprite_plot_scheduler #(
    parameter logic [7:0] ROW_X0       = 8'd10,
    parameter logic [7:0] ALIEN_W      = 8'd11,
    parameter logic [6:0] ALIEN_H      = 7'd9,
    parameter logic [7:0] GAP          = 8'd19,
    parameter logic [6:0] SHIFT_STEP   = 7'd5,
    parameter logic [2:0] BG_COLOUR    = 3'b000,
    parameter logic [2:0] ALIEN_COLOUR = 3'b010,
    parameter logic [2:0] SHOT_COLOUR  = 3'b111
) (
    input logic clk,
    input logic reset,
    sprite_plot_scheduler_if.slave bus
);
    localparam logic [8:0] ROW_X_LAST = {1'b0, ROW_X0} + 9'd5 * {1'b0, ALIEN_W} + 9'd4 * {1'b0, GAP} - 9'd1;
    localparam logic [7:0] PITCH_LAST = ALIEN_W + GAP - 8'd1;
    localparam logic [8:0] SCREEN_W   = 9'd160;
    localparam logic [7:0] SCREEN_H   = 8'd120;

    typedef enum logic [2:0] {
        IDLE, KILL_SCAN, SHIFT_ERASE, SHIFT_FILL, SHOT_ERASE, SHOT_DRAW, ACK, WAIT_DROP
    } state_t;
    typedef enum logic [1:0] {CLS_KILL, CLS_SHIFT, CLS_SHOT} cls_t;

    state_t     state_q, state_n;
    cls_t       cls_q, cls_n;
    logic [2:0] kidx_q, kidx_n;
    logic [8:0] cur_x_q, cur_x_n, x_first_q, x_first_n, x_last_q, x_last_n;
    logic [7:0] cur_y_q, cur_y_n, y_last_q, y_last_n, fill_y_q, fill_y_n;
    logic [7:0] col_off_q, col_off_n;
    logic [2:0] col_idx_q, col_idx_n;
    logic [4:0] cleared_q, cleared_n, alive_q, alive_n;
    logic       cleared_shift_q, cleared_shift_n, shot_done_q, shot_done_n;
    logic [7:0] plot_x_q, plot_x_n;
    logic [6:0] plot_y_q, plot_y_n;
    logic [2:0] plot_colour_q, plot_colour_n;
    logic       plot_q, plot_n, busy_q;

    logic       row_end, last_px, in_screen, col_live, grant_valid, served_req;
    logic [2:0] kill_pick;
    cls_t       grant_cls;
    logic [8:0] step_x;
    logic [7:0] step_y, step_off;
    logic [2:0] step_idx;

    assign row_end   = (cur_x_q == x_last_q);
    assign last_px   = row_end && (cur_y_q == y_last_q);
    assign in_screen = (cur_x_q < SCREEN_W) && (cur_y_q < SCREEN_H);
    assign col_live  = (col_off_q < ALIEN_W) && alive_q[col_idx_q];

    // Raster step shared by every multi-pixel scan; the column tracker follows the alien pitch.
    always_comb begin
        step_x   = cur_x_q + 9'd1;
        step_y   = cur_y_q;
        step_off = col_off_q + 8'd1;
        step_idx = col_idx_q;
        if (row_end) begin
            step_x   = x_first_q;
            step_y   = cur_y_q + 8'd1;
            step_off = '0;
            step_idx = '0;
        end else if (col_off_q == PITCH_LAST) begin
            step_off = '0;
            step_idx = col_idx_q + 3'd1;
        end
    end

    always_comb begin
        kill_pick = '0;
        for (int i = 4; i >= 0; i--) begin
            if (bus.kill_req[i]) kill_pick = 3'(i);
        end
    end

    always_comb begin
        grant_valid = 1'b1;
        grant_cls   = CLS_KILL;
`ifdef SCHED_ROUND_ROBIN_EN
        case (cls_q)
            CLS_KILL: begin
                if (bus.shift_req)      grant_cls = CLS_SHIFT;
                else if (bus.shot_req)  grant_cls = CLS_SHOT;
                else if (|bus.kill_req) grant_cls = CLS_KILL;
                else                    grant_valid = 1'b0;
            end
            CLS_SHIFT: begin
                if (bus.shot_req)       grant_cls = CLS_SHOT;
                else if (|bus.kill_req) grant_cls = CLS_KILL;
                else if (bus.shift_req) grant_cls = CLS_SHIFT;
                else                    grant_valid = 1'b0;
            end
            default: begin
                if (|bus.kill_req)      grant_cls = CLS_KILL;
                else if (bus.shift_req) grant_cls = CLS_SHIFT;
                else if (bus.shot_req)  grant_cls = CLS_SHOT;
                else                    grant_valid = 1'b0;
            end
        endcase
`else
        if (|bus.kill_req)      grant_cls = CLS_KILL;
        else if (bus.shift_req) grant_cls = CLS_SHIFT;
        else if (bus.shot_req)  grant_cls = CLS_SHOT;
        else                    grant_valid = 1'b0;
`endif
    end

    always_comb begin
        case (cls_q)
            CLS_KILL:  served_req = bus.kill_req[kidx_q];
            CLS_SHIFT: served_req = bus.shift_req;
            default:   served_req = bus.shot_req;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_n         = state_q;
        cls_n           = cls_q;
        kidx_n          = kidx_q;
        cur_x_n         = cur_x_q;
        cur_y_n         = cur_y_q;
        x_first_n       = x_first_q;
        x_last_n        = x_last_q;
        y_last_n        = y_last_q;
        fill_y_n        = fill_y_q;
        col_off_n       = col_off_q;
        col_idx_n       = col_idx_q;
        alive_n         = alive_q;
        cleared_n       = '0;
        cleared_shift_n = 1'b0;
        shot_done_n     = 1'b0;
        plot_n          = 1'b0;
        plot_x_n        = cur_x_q[7:0];
        plot_y_n        = cur_y_q[6:0];
        plot_colour_n   = BG_COLOUR;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    cls_n     = grant_cls;
                    col_off_n = '0;
                    col_idx_n = '0;
                    case (grant_cls)
                        CLS_KILL: begin
                            kidx_n    = kill_pick;
                            cur_x_n   = {1'b0, bus.alien_top_x};
                            x_first_n = {1'b0, bus.alien_top_x};
                            x_last_n  = {1'b0, bus.alien_bot_x};
                            cur_y_n   = {1'b0, bus.alien_top_y};
                            y_last_n  = {1'b0, bus.alien_bot_y};
                            if (!alive_q[kill_pick] || (bus.alien_bot_x < bus.alien_top_x) ||
                                (bus.alien_bot_y < bus.alien_top_y))
                                state_n = ACK;
                            else
                                state_n = KILL_SCAN;
                        end
                        CLS_SHIFT: begin
                            cur_x_n   = {1'b0, ROW_X0};
                            x_first_n = {1'b0, ROW_X0};
                            x_last_n  = ROW_X_LAST;
                            cur_y_n   = {1'b0, bus.row_y};
                            y_last_n  = {1'b0, bus.row_y} + {1'b0, SHIFT_STEP} - 8'd1;
                            fill_y_n  = {1'b0, bus.row_y} + {1'b0, ALIEN_H};
                            state_n   = SHIFT_ERASE;
                        end
                        default: begin
                            // Shot reuses the scan registers: cur = old pixel, last = new pixel.
                            cur_x_n  = {1'b0, bus.shot_old_x};
                            cur_y_n  = {1'b0, bus.shot_old_y};
                            x_last_n = {1'b0, bus.shot_new_x};
                            y_last_n = {1'b0, bus.shot_new_y};
                            state_n  = SHOT_ERASE;
                        end
                    endcase
                end
            end
            KILL_SCAN, SHIFT_ERASE, SHIFT_FILL: begin
                plot_n    = in_screen;
                cur_x_n   = step_x;
                cur_y_n   = step_y;
                col_off_n = step_off;
                col_idx_n = step_idx;
                if (state_q == SHIFT_FILL) begin
                    plot_n        = in_screen && col_live;
                    plot_colour_n = ALIEN_COLOUR;
                end
                if (last_px) begin
                    if (state_q == SHIFT_ERASE) begin
                        cur_x_n  = x_first_q;
                        cur_y_n  = fill_y_q;
                        y_last_n = fill_y_q + {1'b0, SHIFT_STEP} - 8'd1;
                        state_n  = SHIFT_FILL;
                    end else begin
                        state_n = ACK;
                    end
                end
            end
            SHOT_ERASE: begin
                plot_n  = in_screen;
                cur_x_n = x_last_q;
                cur_y_n = y_last_q;
                state_n = SHOT_DRAW;
            end
            SHOT_DRAW: begin
                plot_n        = in_screen;
                plot_colour_n = SHOT_COLOUR;
                state_n       = ACK;
            end
            ACK: begin
                case (cls_q)
                    CLS_KILL: begin
                        cleared_n = 5'b00001 << kidx_q;
                        alive_n   = alive_q & ~(5'b00001 << kidx_q);
                    end
                    CLS_SHIFT: cleared_shift_n = 1'b1;
                    default:   shot_done_n     = 1'b1;
                endcase
                state_n = WAIT_DROP;
            end
            default: begin
                if (!served_req) state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cls_q           <= CLS_SHOT;
            kidx_q          <= '0;
            cur_x_q         <= '0;
            cur_y_q         <= '0;
            x_first_q       <= '0;
            x_last_q        <= '0;
            y_last_q        <= '0;
            fill_y_q        <= '0;
            col_off_q       <= '0;
            col_idx_q       <= '0;
            alive_q         <= 5'b11111;
            cleared_q       <= '0;
            cleared_shift_q <= 1'b0;
            shot_done_q     <= 1'b0;
            plot_q          <= 1'b0;
            plot_x_q        <= '0;
            plot_y_q        <= '0;
            plot_colour_q   <= '0;
            busy_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of its neighbours.
            state_q         <= state_n;
            cls_q           <= cls_n;
            kidx_q          <= kidx_n;
            cur_x_q         <= cur_x_n;
            cur_y_q         <= cur_y_n;
            x_first_q       <= x_first_n;
            x_last_q        <= x_last_n;
            y_last_q        <= y_last_n;
            fill_y_q        <= fill_y_n;
            col_off_q       <= col_off_n;
            col_idx_q       <= col_idx_n;
            alive_q         <= alive_n;
            cleared_q       <= cleared_n;
            cleared_shift_q <= cleared_shift_n;
            shot_done_q     <= shot_done_n;
            plot_q          <= plot_n;
            plot_x_q        <= plot_x_n;
            plot_y_q        <= plot_y_n;
            plot_colour_q   <= plot_colour_n;
            busy_q          <= (state_n != IDLE);
        end
    end

    assign bus.cleared       = cleared_q;
    assign bus.cleared_shift = cleared_shift_q;
    assign bus.shot_done     = shot_done_q;
    assign bus.plot_x        = plot_x_q;
    assign bus.plot_y        = plot_y_q;
    assign bus.plot_colour   = plot_colour_q;
    assign bus.plot          = plot_q;
    assign bus.busy          = busy_q;
    assign bus.alive_mask    = alive_q;
endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Directed bench for sprite_plot_scheduler: plot streams are compared against a reference pixel model.
module tb_sprite_plot_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_plot_scheduler_if bus();
    sprite_plot_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { int x; int y; int c; int cyc; } pix_t;
    pix_t got[$];
    pix_t exp_q[$];
    int   ack_kill_cyc[$];
    int   ack_shift_cyc[$];
    int   ack_shot_cyc[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.plot === 1'b1) got.push_back('{int'(bus.plot_x), int'(bus.plot_y), int'(bus.plot_colour), cyc});
        if (|bus.cleared) ack_kill_cyc.push_back(cyc);
        if (bus.cleared_shift === 1'b1) ack_shift_cyc.push_back(cyc);
        if (bus.shot_done === 1'b1) ack_shot_cyc.push_back(cyc);
    end

    task automatic idle_inputs();
        bus.kill_req = '0; bus.shift_req = 1'b0; bus.shot_req = 1'b0;
        bus.alien_top_x = '0; bus.alien_top_y = '0; bus.alien_bot_x = '0; bus.alien_bot_y = '0;
        bus.row_y = '0; bus.shot_old_x = '0; bus.shot_old_y = '0; bus.shot_new_x = '0; bus.shot_new_y = '0;
    endtask

    task automatic clear_logs();
        got.delete(); exp_q.delete();
        ack_kill_cyc.delete(); ack_shift_cyc.delete(); ack_shot_cyc.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // kind: 0 kill ack, 1 shift ack, 2 shot ack, 3 idle
    task automatic wait_sig(input int kind, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (kind)
                0: ok = |bus.cleared;
                1: ok = bus.cleared_shift;
                2: ok = bus.shot_done;
                default: ok = !bus.busy;
            endcase
            if (ok) break;
        end
    endtask

    task automatic set_box(input int tx, input int ty, input int bx, input int by);
        bus.alien_top_x = 8'(tx); bus.alien_top_y = 7'(ty);
        bus.alien_bot_x = 8'(bx); bus.alien_bot_y = 7'(by);
    endtask

    task automatic set_shot(input int ox, input int oy, input int nx, input int ny);
        bus.shot_old_x = 8'(ox); bus.shot_old_y = 7'(oy);
        bus.shot_new_x = 8'(nx); bus.shot_new_y = 7'(ny);
    endtask

    function automatic void exp_pix(input int x, input int y, input int c);
        if (x < 160 && y < 120) exp_q.push_back('{x, y, c, 0});
    endfunction

    function automatic void exp_box(input int tx, input int ty, input int bx, input int by);
        for (int y = ty; y <= by; y++)
            for (int x = tx; x <= bx; x++) exp_pix(x, y, 0);
    endfunction

    function automatic void exp_shift(input int ry, input logic [4:0] alive);
        for (int y = ry; y < ry + 5; y++)
            for (int x = 10; x <= 140; x++) exp_pix(x, y, 0);
        for (int y = ry + 9; y < ry + 14; y++)
            for (int x = 10; x <= 140; x++)
                if (((x - 10) % 30) < 11 && alive[(x - 10) / 30]) exp_pix(x, y, 2);
    endfunction

    function automatic int stream_diffs();
        int d = (got.size() > exp_q.size()) ? got.size() - exp_q.size() : exp_q.size() - got.size();
        int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got[i].x != exp_q[i].x || got[i].y != exp_q[i].y || got[i].c != exp_q[i].c) d++;
        return d;
    endfunction

    function automatic int cnt_row(input int y);
        int n = 0;
        foreach (got[i]) if (got[i].y == y) n++;
        return n;
    endfunction

    task automatic test_reset();
        tick(1);
        n_vec++; if (bus.plot !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_plot_busy: got %b/%b want 0/0", bus.plot, bus.busy); end
        n_vec++; if (bus.alive_mask !== 5'b11111) begin n_err++; $display("FAIL reset_alive: got %b want 11111", bus.alive_mask); end
        n_vec++; if (bus.cleared !== 5'b0 || bus.cleared_shift !== 1'b0 || bus.shot_done !== 1'b0) begin n_err++; $display("FAIL reset_acks: got %b/%b/%b want 0", bus.cleared, bus.cleared_shift, bus.shot_done); end
        n_vec++; if (bus.plot_x !== 8'd0 || bus.plot_y !== 7'd0 || bus.plot_colour !== 3'd0) begin n_err++; $display("FAIL reset_coords: got %0d,%0d,%0d want 0", bus.plot_x, bus.plot_y, bus.plot_colour); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_kill_raster();
        bit ok; int c0, first, last;
        clear_logs(); exp_box(10, 20, 21, 29);
        set_box(10, 20, 21, 29);
        c0 = cyc; bus.kill_req = 5'b00001;
        tick(5);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL kill_busy: got %b want 1", bus.busy); end
        wait_sig(0, 400, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL kill_timeout: no cleared within budget"); end
        n_vec++; if (bus.cleared !== 5'b00001) begin n_err++; $display("FAIL kill_ack: got %b want 00001", bus.cleared); end
        n_vec++; if (bus.alive_mask !== 5'b11110) begin n_err++; $display("FAIL kill_alive: got %b want 11110", bus.alive_mask); end
        n_vec++; if (got.size() != 120) begin n_err++; $display("FAIL kill_count: got %0d want 120", got.size()); end
        n_vec++; if (stream_diffs() != 0) begin n_err++; $display("FAIL kill_raster: %0d pixel differences", stream_diffs()); end
        first = (got.size() > 0) ? got[0].cyc : -1;
        last  = (got.size() > 0) ? got[got.size()-1].cyc : -1;
        n_vec++; if (first != c0 + 2) begin n_err++; $display("FAIL kill_latency: first plot cycle %0d want %0d", first, c0 + 2); end
        n_vec++; if (last - first != 119) begin n_err++; $display("FAIL kill_contiguous: span %0d want 119", last - first); end
        n_vec++; if (ack_kill_cyc.size() != 1 || ack_kill_cyc[0] != last + 1) begin n_err++; $display("FAIL kill_ack_latency: acks %0d last plot %0d", ack_kill_cyc.size(), last); end
        tick(1);
        n_vec++; if (bus.cleared !== 5'b0) begin n_err++; $display("FAIL kill_ack_width: got %b want 00000", bus.cleared); end
        bus.kill_req = '0;
        wait_sig(3, 10, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL kill_release: busy stuck high"); end
    endtask

    task automatic test_shift();
        bit ok; int c0;
        do_reset();
        n_vec++; if (bus.alive_mask !== 5'b11111) begin n_err++; $display("FAIL shift_alive_reset: got %b want 11111", bus.alive_mask); end
        clear_logs(); exp_shift(10, 5'b11111);
        bus.row_y = 7'd10;
        c0 = cyc; bus.shift_req = 1'b1;
        wait_sig(1, 2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL shift_timeout: no cleared_shift"); end
        n_vec++; if (got.size() != 930) begin n_err++; $display("FAIL shift_count: got %0d want 930", got.size()); end
        n_vec++; if (stream_diffs() != 0) begin n_err++; $display("FAIL shift_stream: %0d pixel differences", stream_diffs()); end
        n_vec++; if (cnt_row(19) != 55 || cnt_row(12) != 131) begin n_err++; $display("FAIL shift_row_counts: fill %0d want 55, erase %0d want 131", cnt_row(19), cnt_row(12)); end
        n_vec++; if (ack_shift_cyc.size() != 1 || ack_shift_cyc[0] != c0 + 1312) begin n_err++; $display("FAIL shift_ack_cycle: acks %0d want one at %0d", ack_shift_cyc.size(), c0 + 1312); end
        tick(1); bus.shift_req = 1'b0;
        wait_sig(3, 10, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL shift_release: busy stuck high"); end
    endtask

    task automatic test_tie_after_shift();
        bit ok, kill_first;
        int kc, sc;
`ifdef SCHED_ROUND_ROBIN_EN
        kill_first = 1'b0;
`else
        kill_first = 1'b1;
`endif
        clear_logs();
        if (kill_first) begin exp_box(140, 5, 141, 5); exp_pix(60, 60, 0); exp_pix(61, 60, 7); end
        else begin exp_pix(60, 60, 0); exp_pix(61, 60, 7); exp_box(140, 5, 141, 5); end
        set_box(140, 5, 141, 5); set_shot(60, 60, 61, 60);
        bus.kill_req = 5'b10000; bus.shot_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack_kill_cyc.size() > 0 && ack_kill_cyc[0] < cyc) bus.kill_req = '0;
            if (ack_shot_cyc.size() > 0 && ack_shot_cyc[0] < cyc) bus.shot_req = 1'b0;
            if (ack_kill_cyc.size() > 0 && ack_shot_cyc.size() > 0) break;
        end
        kc = (ack_kill_cyc.size() > 0) ? ack_kill_cyc[0] : -1;
        sc = (ack_shot_cyc.size() > 0) ? ack_shot_cyc[0] : -1;
        n_vec++; if (kc < 0 || sc < 0) begin n_err++; $display("FAIL tie_timeout: kill ack %0d shot ack %0d", kc, sc); end
        n_vec++; if ((kc < sc) !== kill_first) begin n_err++; $display("FAIL tie_order: kill ack %0d shot ack %0d, kill first want %0d", kc, sc, kill_first); end
        n_vec++; if (stream_diffs() != 0) begin n_err++; $display("FAIL tie_stream: %0d pixel differences", stream_diffs()); end
        bus.kill_req = '0; bus.shot_req = 1'b0;
        wait_sig(3, 10, ok);
        n_vec++; if (!ok || bus.alive_mask !== 5'b01111) begin n_err++; $display("FAIL tie_alive: got %b want 01111", bus.alive_mask); end
    endtask

    task automatic test_kill_and_shot();
        bit ok;
        do_reset();
        clear_logs(); exp_box(70, 20, 80, 28); exp_pix(50, 100, 0); exp_pix(51, 99, 7);
        set_box(70, 20, 80, 28); set_shot(50, 100, 51, 99);
        bus.kill_req = 5'b00100; bus.shot_req = 1'b1;
        wait_sig(0, 300, ok);
        n_vec++; if (!ok || bus.cleared !== 5'b00100) begin n_err++; $display("FAIL ks_kill_ack: got %b want 00100", bus.cleared); end
        n_vec++; if (ack_shot_cyc.size() != 0 || got.size() != 99) begin n_err++; $display("FAIL ks_kill_first: shot acks %0d plots %0d want 0/99", ack_shot_cyc.size(), got.size()); end
        tick(1); bus.kill_req = '0;
        wait_sig(2, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ks_shot_timeout: no shot_done"); end
        n_vec++; if (got.size() != 101 || stream_diffs() != 0) begin n_err++; $display("FAIL ks_stream: %0d plots %0d differences want 101/0", got.size(), stream_diffs()); end
        n_vec++; if (got.size() < 2 || ack_shot_cyc[0] != got[got.size()-1].cyc + 1 || got[got.size()-1].cyc != got[got.size()-2].cyc + 1) begin n_err++; $display("FAIL ks_shot_timing: shot_done cycle %0d", cyc); end
        tick(1); bus.shot_req = 1'b0;
        wait_sig(3, 10, ok);
        n_vec++; if (!ok || bus.alive_mask !== 5'b11011) begin n_err++; $display("FAIL ks_alive: got %b want 11011", bus.alive_mask); end
    endtask

    task automatic test_kill_shift_tie();
        bit ok;
        clear_logs(); exp_box(100, 30, 102, 31); exp_shift(105, 5'b10011);
        set_box(100, 30, 102, 31); bus.row_y = 7'd105;
        bus.kill_req = 5'b01000; bus.shift_req = 1'b1;
        wait_sig(0, 100, ok);
        n_vec++; if (!ok || bus.cleared !== 5'b01000 || ack_shift_cyc.size() != 0) begin n_err++; $display("FAIL tie2_kill_first: cleared %b shift acks %0d", bus.cleared, ack_shift_cyc.size()); end
        tick(1); bus.kill_req = '0;
        wait_sig(1, 2000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL tie2_shift_timeout: no cleared_shift"); end
        n_vec++; if (got.size() != 826 || stream_diffs() != 0) begin n_err++; $display("FAIL tie2_stream: %0d plots %0d differences want 826/0", got.size(), stream_diffs()); end
        n_vec++; if (cnt_row(116) != 33) begin n_err++; $display("FAIL tie2_dead_fill: row 116 got %0d want 33", cnt_row(116)); end
        tick(1); bus.shift_req = 1'b0;
        wait_sig(3, 10, ok);
    endtask

    task automatic test_held_kill();
        bit ok; int c0;
        clear_logs();
        set_box(30, 40, 32, 41);
        bus.kill_req = 5'b00010;
        wait_sig(0, 100, ok);
        tick(3); bus.kill_req = '0;
        wait_sig(3, 10, ok);
        n_vec++; if (ack_kill_cyc.size() != 1 || got.size() != 6) begin n_err++; $display("FAIL held_once: acks %0d plots %0d want 1/6", ack_kill_cyc.size(), got.size()); end
        n_vec++; if (bus.alive_mask !== 5'b10001) begin n_err++; $display("FAIL held_alive: got %b want 10001", bus.alive_mask); end
        clear_logs();
        c0 = cyc; bus.kill_req = 5'b00010;
        wait_sig(0, 10, ok);
        n_vec++; if (!ok || bus.cleared !== 5'b00010 || got.size() != 0) begin n_err++; $display("FAIL dead_ack: cleared %b plots %0d want 00010/0", bus.cleared, got.size()); end
        n_vec++; if (ack_kill_cyc.size() != 1 || ack_kill_cyc[0] != c0 + 2) begin n_err++; $display("FAIL dead_latency: ack cycle %0d want %0d", cyc, c0 + 2); end
        tick(1); bus.kill_req = '0;
        wait_sig(3, 10, ok);
        clear_logs();
        set_box(50, 50, 49, 60);
        bus.kill_req = 5'b00001;
        wait_sig(0, 10, ok);
        n_vec++; if (!ok || bus.cleared !== 5'b00001 || got.size() != 0) begin n_err++; $display("FAIL empty_box: cleared %b plots %0d want 00001/0", bus.cleared, got.size()); end
        n_vec++; if (bus.alive_mask !== 5'b10000) begin n_err++; $display("FAIL empty_box_alive: got %b want 10000", bus.alive_mask); end
        tick(1); bus.kill_req = '0;
        wait_sig(3, 10, ok);
    endtask

    task automatic test_shot_offscreen();
        bit ok; int c0;
        clear_logs();
        set_shot(20, 30, 165, 50);
        c0 = cyc; bus.shot_req = 1'b1;
        wait_sig(2, 20, ok);
        n_vec++; if (!ok || ack_shot_cyc.size() != 1 || ack_shot_cyc[0] != c0 + 4) begin n_err++; $display("FAIL shot_off_ack: acks %0d at cycle %0d want %0d", ack_shot_cyc.size(), cyc, c0 + 4); end
        n_vec++; if (got.size() != 1 || got[0].x != 20 || got[0].y != 30 || got[0].c != 0) begin n_err++; $display("FAIL shot_off_plots: got %0d plots want 1 at (20,30) colour 0", got.size()); end
        tick(1); bus.shot_req = 1'b0;
        wait_sig(3, 10, ok);
    endtask

    task automatic test_shift_clip();
        bit ok; int c0;
        clear_logs(); exp_shift(115, 5'b10000);
        bus.row_y = 7'd115;
        c0 = cyc; bus.shift_req = 1'b1;
        wait_sig(1, 2000, ok);
        n_vec++; if (!ok || got.size() != 655 || stream_diffs() != 0) begin n_err++; $display("FAIL clip_stream: %0d plots %0d differences want 655/0", got.size(), stream_diffs()); end
        n_vec++; if (ack_shift_cyc.size() != 1 || ack_shift_cyc[0] != c0 + 1312) begin n_err++; $display("FAIL clip_ack_cycle: acks %0d want one at %0d", ack_shift_cyc.size(), c0 + 1312); end
        tick(1); bus.shift_req = 1'b0;
        wait_sig(3, 10, ok);
    endtask

    task automatic test_reset_mid_shift();
        clear_logs();
        bus.row_y = 7'd20; bus.shift_req = 1'b1;
        tick(30);
        n_vec++; if (bus.busy !== 1'b1 || got.size() == 0) begin n_err++; $display("FAIL mid_shift_active: busy %b plots %0d", bus.busy, got.size()); end
        reset = 1'b1;
        #1;
        n_vec++; if (bus.plot !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_outputs: plot %b busy %b want 0/0", bus.plot, bus.busy); end
        n_vec++; if (bus.alive_mask !== 5'b11111 || bus.cleared_shift !== 1'b0) begin n_err++; $display("FAIL mid_reset_state: alive %b ack %b want 11111/0", bus.alive_mask, bus.cleared_shift); end
        bus.shift_req = 1'b0;
        tick(2); reset = 1'b0;
        clear_logs();
        tick(1400);
        n_vec++; if (ack_shift_cyc.size() != 0 || got.size() != 0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_abort: acks %0d plots %0d busy %b want 0", ack_shift_cyc.size(), got.size(), bus.busy); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_kill_raster();
        test_shift();
        test_tie_after_shift();
        test_kill_and_shot();
        test_kill_shift_tie();
        test_held_kill();
        test_shot_offscreen();
        test_shift_clip();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
